// File: rtl/rc4_decrypt_engine.sv
// RC4 decryption engine: S-array init, key scheduling and PRGA/XOR over a ciphertext ROM,
// writing plaintext to RAM and flagging whether every byte is lowercase ASCII or space.
module rc4_decrypt_engine #(
  parameter int KEY_BYTES    = 3,
  parameter int MSG_LEN      = 32,
  parameter int MSG_AW       = 5,
  parameter int ABORT_ON_BAD = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic                   busy,
  output logic                   done,
  output logic                   ascii_ok,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wdata,
  output logic                   s_wren,
  input  logic [7:0]             s_rdata,
  output logic [MSG_AW-1:0]      ct_addr,
  input  logic [7:0]             ct_rdata,
  output logic [MSG_AW-1:0]      pt_addr,
  output logic [7:0]             pt_wdata,
  output logic                   pt_wren
);

  typedef enum logic [4:0] {
    IDLE, INIT,
    KSA_RDI, KSA_RDI_W, KSA_RDJ, KSA_RDJ_W, KSA_WRI, KSA_WRJ,
    PR_RDI, PR_RDI_W, PR_RDJ, PR_RDJ_W, PR_WRI, PR_WRJ, PR_RDF, PR_RDF_W,
    DONE
  } state_t;

  state_t            r_state, w_next;
  logic [7:0]        r_i, r_j, r_kidx, r_si, r_sj;
  logic [MSG_AW-1:0] r_k;
  logic              r_ascii;
  logic [7:0]        w_key_byte, w_pt;
  logic              w_pt_ok, w_last_i, w_last_k, w_exit;

  // Key byte 0 sits in the most significant byte of the key bus.
  always_comb begin
    w_key_byte = 8'h00;
    for (int n = 0; n < KEY_BYTES; n++) begin
      if (r_kidx == 8'(n)) w_key_byte = key[8*(KEY_BYTES-n)-1 -: 8];
    end
  end

  assign w_pt     = s_rdata ^ ct_rdata;
  assign w_pt_ok  = ((w_pt >= 8'h61) && (w_pt <= 8'h7A)) || (w_pt == 8'h20);
  assign w_last_i = (r_i == 8'hFF);
  assign w_last_k = (r_k == MSG_AW'(MSG_LEN - 1));
  assign w_exit   = w_last_k || ((ABORT_ON_BAD != 0) && !w_pt_ok);
  assign ascii_ok = r_ascii;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    busy     = (r_state != IDLE) && (r_state != DONE);
    done     = 1'b0;
    s_addr   = 8'h00;
    s_wdata  = 8'h00;
    s_wren   = 1'b0;
    ct_addr  = '0;
    pt_addr  = '0;
    pt_wdata = 8'h00;
    pt_wren  = 1'b0;
    case (r_state)
      IDLE:      if (start) w_next = INIT;
      INIT: begin
        s_addr  = r_i;
        s_wdata = r_i;
        s_wren  = 1'b1;
        if (w_last_i) w_next = KSA_RDI;
      end
      KSA_RDI: begin
        s_addr = r_i;
        w_next = KSA_RDI_W;
      end
      KSA_RDI_W: w_next = KSA_RDJ;
      KSA_RDJ: begin
        s_addr = r_j;
        w_next = KSA_RDJ_W;
      end
      KSA_RDJ_W: w_next = KSA_WRI;
      KSA_WRI: begin
        s_addr  = r_i;
        s_wdata = r_sj;
        s_wren  = 1'b1;
        w_next  = KSA_WRJ;
      end
      // The j write lands last so an i==j swap leaves S unchanged.
      KSA_WRJ: begin
        s_addr  = r_j;
        s_wdata = r_si;
        s_wren  = 1'b1;
        w_next  = w_last_i ? PR_RDI : KSA_RDI;
      end
      PR_RDI: begin
        s_addr = r_i;
        w_next = PR_RDI_W;
      end
      PR_RDI_W: w_next = PR_RDJ;
      PR_RDJ: begin
        s_addr = r_j;
        w_next = PR_RDJ_W;
      end
      PR_RDJ_W: w_next = PR_WRI;
      PR_WRI: begin
        s_addr  = r_i;
        s_wdata = r_sj;
        s_wren  = 1'b1;
        w_next  = PR_WRJ;
      end
      PR_WRJ: begin
        s_addr  = r_j;
        s_wdata = r_si;
        s_wren  = 1'b1;
        w_next  = PR_RDF;
      end
      PR_RDF: begin
        s_addr  = r_si + r_sj;
        ct_addr = r_k;
        w_next  = PR_RDF_W;
      end
      PR_RDF_W: begin
        pt_addr  = r_k;
        pt_wdata = w_pt;
        pt_wren  = 1'b1;
        w_next   = w_exit ? DONE : PR_RDI;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_i     <= 8'h00;
      r_j     <= 8'h00;
      r_k     <= '0;
      r_kidx  <= 8'h00;
      r_ascii <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_ascii <= 1'b1;
          r_i     <= 8'h00;
          r_j     <= 8'h00;
          r_k     <= '0;
          r_kidx  <= 8'h00;
        end
        INIT:      r_i <= r_i + 8'h01;
        KSA_RDI_W: r_j <= r_j + s_rdata + w_key_byte;
        KSA_WRJ: begin
          r_kidx <= (r_kidx == 8'(KEY_BYTES - 1)) ? 8'h00 : r_kidx + 8'h01;
          if (w_last_i) begin
            r_i <= 8'h01;
            r_j <= 8'h00;
            r_k <= '0;
          end else begin
            r_i <= r_i + 8'h01;
          end
        end
        PR_RDI_W:  r_j <= r_j + s_rdata;
        PR_RDF_W: begin
          r_ascii <= r_ascii & w_pt_ok;
          if (!w_exit) begin
            r_k <= r_k + 1'b1;
            r_i <= r_i + 8'h01;
          end
        end
        default: ;
      endcase
    end
  end

  // Swap operands are pure data and need no reset.
  always_ff @(posedge clk) begin
    if (r_state == KSA_RDI_W || r_state == PR_RDI_W) r_si <= s_rdata;
    if (r_state == KSA_RDJ_W || r_state == PR_RDJ_W) r_sj <= s_rdata;
  end

endmodule

// File: tb/tb_rc4_decrypt_engine.sv
// Scoreboard bench for rc4_decrypt_engine: three instances ("Key" full, "Key" abort-on-bad, "Wiki")
// run in lockstep against behavioural S memory, ciphertext ROM and plaintext RAM models.
module tb_rc4_decrypt_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, start;
  logic       busy_v[3], done_v[3], ok_v[3], s_wren_v[3], pt_wren_v[3];
  logic [7:0] s_addr_v[3], s_wdata_v[3], s_rdata_v[3], pt_wdata_v[3], ct_rdata_v[3];
  logic [3:0] ct_addr_v[3], pt_addr_v[3];
  logic [7:0] smem[3][256];
  logic [7:0] ctm[3][16];
  logic [7:0] ptm[3][16];

  localparam logic [23:0] KEY_A = 24'h4B6579;
  localparam logic [31:0] KEY_C = 32'h57696B69;

  logic [7:0] cta[9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] pta[9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] ctc[5] = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
  logic [7:0] ptc[5] = '{8'h70, 8'h65, 8'h64, 8'h69, 8'h61};

  typedef struct packed {logic [3:0] a; logic [7:0] d;} pt_t;
  pt_t q0[$], q1[$], q2[$];

  int   n_cmp = 0, n_fail = 0;
  int   tick = 0, t0 = 0;
  int   ndone[3], nwr[3];
  int   exp_done[3] = '{1865, 1801, 1833};
  logic exp_ok[3]   = '{1'b0, 1'b0, 1'b1};

  rc4_decrypt_engine #(.KEY_BYTES(3), .MSG_LEN(9), .MSG_AW(4), .ABORT_ON_BAD(0)) u_a (
    .clk(clk), .reset_n(reset_n), .start(start), .key(KEY_A),
    .busy(busy_v[0]), .done(done_v[0]), .ascii_ok(ok_v[0]),
    .s_addr(s_addr_v[0]), .s_wdata(s_wdata_v[0]), .s_wren(s_wren_v[0]), .s_rdata(s_rdata_v[0]),
    .ct_addr(ct_addr_v[0]), .ct_rdata(ct_rdata_v[0]),
    .pt_addr(pt_addr_v[0]), .pt_wdata(pt_wdata_v[0]), .pt_wren(pt_wren_v[0]));

  rc4_decrypt_engine #(.KEY_BYTES(3), .MSG_LEN(9), .MSG_AW(4), .ABORT_ON_BAD(1)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start), .key(KEY_A),
    .busy(busy_v[1]), .done(done_v[1]), .ascii_ok(ok_v[1]),
    .s_addr(s_addr_v[1]), .s_wdata(s_wdata_v[1]), .s_wren(s_wren_v[1]), .s_rdata(s_rdata_v[1]),
    .ct_addr(ct_addr_v[1]), .ct_rdata(ct_rdata_v[1]),
    .pt_addr(pt_addr_v[1]), .pt_wdata(pt_wdata_v[1]), .pt_wren(pt_wren_v[1]));

  rc4_decrypt_engine #(.KEY_BYTES(4), .MSG_LEN(5), .MSG_AW(4), .ABORT_ON_BAD(0)) u_c (
    .clk(clk), .reset_n(reset_n), .start(start), .key(KEY_C),
    .busy(busy_v[2]), .done(done_v[2]), .ascii_ok(ok_v[2]),
    .s_addr(s_addr_v[2]), .s_wdata(s_wdata_v[2]), .s_wren(s_wren_v[2]), .s_rdata(s_rdata_v[2]),
    .ct_addr(ct_addr_v[2]), .ct_rdata(ct_rdata_v[2]),
    .pt_addr(pt_addr_v[2]), .pt_wdata(pt_wdata_v[2]), .pt_wren(pt_wren_v[2]));

  always @(posedge clk) tick <= tick + 1;

  // Memory models: synchronous, one-cycle read latency.
  always @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (s_wren_v[n]) smem[n][s_addr_v[n]] <= s_wdata_v[n];
      s_rdata_v[n]  <= smem[n][s_addr_v[n]];
      ct_rdata_v[n] <= ctm[n][ct_addr_v[n]];
      if (pt_wren_v[n]) ptm[n][pt_addr_v[n]] <= pt_wdata_v[n];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic pop_chk(input int n, input logic [3:0] a, input logic [7:0] d);
    pt_t e;
    bit  have;
    have = 1'b0;
    e    = '0;
    case (n)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (have) begin
      chk($sformatf("pt_write[%0d]", n), {a, d}, {e.a, e.d});
    end else begin
      n_cmp++;
      n_fail++;
      $display("FAIL pt_unexpected[%0d]: got write addr %0h data %0h, required none", n, a, d);
    end
  endtask

  // Monitor: every plaintext write and done pulse is checked against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int n = 0; n < 3; n++) begin
        if (pt_wren_v[n]) begin
          nwr[n]++;
          pop_chk(n, pt_addr_v[n], pt_wdata_v[n]);
          chk($sformatf("single_wren[%0d]", n), s_wren_v[n], 0);
        end
        if (done_v[n]) begin
          ndone[n]++;
          chk($sformatf("done_cycle[%0d]", n), tick - t0, exp_done[n]);
          chk($sformatf("ascii_at_done[%0d]", n), ok_v[n], exp_ok[n]);
          chk($sformatf("busy_at_done[%0d]", n), busy_v[n], 0);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("%s_busy[%0d]", tag, n), busy_v[n], 0);
      chk($sformatf("%s_done[%0d]", tag, n), done_v[n], 0);
      chk($sformatf("%s_ascii[%0d]", tag, n), ok_v[n], 0);
      chk($sformatf("%s_wren[%0d]", tag, n), {s_wren_v[n], pt_wren_v[n]}, 0);
    end
  endtask

  task automatic run_seq(input bit pulses, input int rst_at);
    int bad;
    q0.delete(); q1.delete(); q2.delete();
    for (int n = 0; n < 3; n++) begin ndone[n] = 0; nwr[n] = 0; end
    for (int k = 0; k < 9; k++) q0.push_back(pt_t'{a: 4'(k), d: pta[k]});
    q1.push_back(pt_t'{a: 4'h0, d: 8'h50});
    for (int k = 0; k < 5; k++) q2.push_back(pt_t'{a: 4'(k), d: ptc[k]});
    for (int n = 0; n < 3; n++) for (int k = 0; k < 16; k++) ptm[n][k] = 8'h00;

    @(negedge clk);
    start = 1'b1;
    t0    = tick;
    for (int c = 1; c <= 1875; c++) begin
      @(negedge clk);
      start = pulses && (c == 5 || c == 1500);
      if (c == 1) for (int n = 0; n < 3; n++) chk($sformatf("busy_rise[%0d]", n), busy_v[n], 1);
      if (c == 257) begin
        for (int n = 0; n < 3; n++) begin
          bad = 0;
          for (int i = 0; i < 256; i++) if (smem[n][i] !== 8'(i)) bad++;
          chk($sformatf("init_s_bad_entries[%0d]", n), bad, 0);
          chk($sformatf("init_busy[%0d]", n), busy_v[n], 1);
          chk($sformatf("init_no_pt[%0d]", n), nwr[n], 0);
        end
      end
      if (c == rst_at) begin
        reset_n = 1'b0;
        #1;
        check_idle_outputs("midrun_reset");
        @(negedge clk);
        reset_n = 1'b1;
        start   = 1'b0;
        q0.delete(); q1.delete(); q2.delete();
        return;
      end
    end
    start = 1'b0;
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("done_count[%0d]", n), ndone[n], 1);
      chk($sformatf("ascii_hold[%0d]", n), ok_v[n], exp_ok[n]);
      chk($sformatf("busy_end[%0d]", n), busy_v[n], 0);
    end
    chk("pending_a", q0.size(), 0);
    chk("pending_b", q1.size(), 0);
    chk("pending_c", q2.size(), 0);
    chk("writes_b", nwr[1], 1);
    chk("pt_ram_b1_untouched", ptm[1][1], 8'h00);
    for (int k = 0; k < 5; k++) chk($sformatf("pt_ram_c[%0d]", k), ptm[2][k], ptc[k]);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    for (int n = 0; n < 3; n++) for (int k = 0; k < 16; k++) ctm[n][k] = 8'h00;
    for (int k = 0; k < 9; k++) begin ctm[0][k] = cta[k]; ctm[1][k] = cta[k]; end
    for (int k = 0; k < 5; k++) ctm[2][k] = ctc[k];
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    run_seq(1'b1, -1);
    run_seq(1'b0, 1000);
    run_seq(1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rc4_decrypt_engine.md
# rc4_decrypt_engine

Parametrised RC4 decryption engine, the successor of the fixed-key fill/shuffle datapath in the ksa top level. On `start` it runs S-array initialisation, the key-scheduling pass with a `KEY_BYTES`-byte key, and the PRGA/XOR pass over a `MSG_LEN`-byte ciphertext. It writes the plaintext to an external RAM and reports whether every byte is lowercase ASCII or space. It drives an external single-port S memory (the `s_memory` type), a ciphertext ROM and a plaintext RAM, and sits under the key-search controller.

## Interface
- `KEY_BYTES`, default 3: key length in bytes, 1..256.
- `MSG_LEN`, default 32: message length in bytes, 1..256.
- `MSG_AW`, default 5: message address width; `2**MSG_AW >= MSG_LEN`.
- `ABORT_ON_BAD`, default 0: when 1, stop at the first plaintext byte that fails the ASCII check.

- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin decryption. Sampled only in IDLE.
- `key` in 8*KEY_BYTES: key byte n = `key[8*(KEY_BYTES-n)-1 -: 8]`, so byte 0 is the MSB byte. Must be held stable while `busy`.
- `busy` out 1: high in INIT, KSA and PRGA.
- `done` out 1: one-cycle pulse at completion or abort.
- `ascii_ok` out 1: result flag. Valid from the `done` cycle until the next accepted `start`.
- `s_addr` out 8, `s_wdata` out 8, `s_wren` out 1, `s_rdata` in 8: S memory port, 1-cycle read latency.
- `ct_addr` out MSG_AW, `ct_rdata` in 8: ciphertext ROM port, 1-cycle read latency.
- `pt_addr` out MSG_AW, `pt_wdata` out 8, `pt_wren` out 1: plaintext RAM write port.

## Operation
- States: IDLE, INIT, KSA_RDI, KSA_RDI_W, KSA_RDJ, KSA_RDJ_W, KSA_WRI, KSA_WRJ, PR_RDI, PR_RDI_W, PR_RDJ, PR_RDJ_W, PR_WRI, PR_WRJ, PR_RDF, PR_RDF_W, DONE.
- All index arithmetic is 8-bit modulo 256. `i` and `j` are 8-bit. Key index is `i mod KEY_BYTES`, implemented as a wrapping counter with no divider.
- IDLE:
  - On `start`: clear `ascii_ok` to 1, zero `i`, `j` and `k`, go to INIT.
  - All write enables are 0 in IDLE.
- INIT: write `s[i]=i` for i=0..255, one write per cycle. After i=255, go to KSA_RDI with `i=0`, `j=0`.
- KSA, for each i=0..255:
  - KSA_RDI: `s_addr=i`.
  - KSA_RDI_W: latch `si=s_rdata`; `j<=j+si+key[i mod KEY_BYTES]`.
  - KSA_RDJ: `s_addr=j`.
  - KSA_RDJ_W: latch `sj`.
  - KSA_WRI: write `s[i]=sj`.
  - KSA_WRJ: write `s[j]=si`; advance `i`. After i=255, go to PR_RDI with `j=0`, `k=0`.
- PRGA, for each k=0..MSG_LEN-1, with `i=k+1`:
  - PR_RDI / PR_RDI_W: read and latch `si`; `j<=j+si`.
  - PR_RDJ / PR_RDJ_W: read and latch `sj`.
  - PR_WRI: write `s[i]=sj`.
  - PR_WRJ: write `s[j]=si`.
  - PR_RDF: `s_addr=si+sj`, `ct_addr=k`.
  - PR_RDF_W: `pt_addr=k`, `pt_wdata=s_rdata^ct_rdata`, `pt_wren=1`. `ascii_ok` is ANDed with (`pt_wdata` in 0x61..0x7A or equal to 0x20).
- Exit from PR_RDF_W:
  - If k=MSG_LEN-1, go to DONE.
  - If `ABORT_ON_BAD=1` and the byte failed the check, go to DONE (abort).
  - Otherwise `k<=k+1` and go to PR_RDI.
- DONE: `done=1` for one cycle, then IDLE. `ascii_ok` holds.
- `start` while `busy` or in DONE is ignored.
- `key` changing mid-run is undefined; `key` is not registered.
- Reset, including mid-operation: state to IDLE, all outputs 0 (`ascii_ok` 0), `i=j=k=0`. No partial S or PT writes are retracted.
- If `i==j` in the swap, the two writes are sequential, and KSA_WRJ's write is the final one (correct RC4 semantics).

## Timing
- Cycle 0: `start` sampled in IDLE.
- INIT: cycles 1..256.
- KSA: cycles 257..1792 (6 cycles per i).
- PRGA: 8 cycles per byte, cycles 1793..1792+8*MSG_LEN.
- `done` at cycle 1793+8*MSG_LEN. Example: MSG_LEN=32 gives cycle 2049.
- Abort at byte k: `done` at cycle 1793+8*(k+1).
- `busy` rises at cycle 1 and falls in the `done` cycle. The next `start` is accepted the cycle after `done`.
- At most one of `s_wren` / `pt_wren` is asserted per cycle. Write enables are combinational from state.

## Test plan
- INIT check: stop the bench model after cycle 256 -> S memory holds `s[i]=i` for all i, `busy`=1, no `pt_wren` yet.
- KEY_BYTES=3, key 0x4B6579 ("Key"), MSG_LEN=9, ct BB F3 16 E8 D9 40 AF 0A D3 -> pt 50 6C 61 69 6E 74 65 78 74 ("Plaintext"); `done` at cycle 1865; `ascii_ok`=0 ('P' is not lowercase).
- Same key, ABORT_ON_BAD=1 -> only pt[0]=0x50 written; `done` at cycle 1801; `ascii_ok`=0.
- KEY_BYTES=4, key 0x57696B69 ("Wiki"), MSG_LEN=5, ct 10 21 BF 04 20 -> pt "pedia" (70 65 64 69 61); `ascii_ok`=1; `done` at cycle 1833.
- Reset deasserted-asserted at cycle 1000 mid-KSA -> `busy`=`done`=`ascii_ok`=0 immediately; a new `start` reruns the full sequence with identical results and cycle counts.
- `start` pulsed at cycles 5 and 1500 of a run -> both ignored; exactly one `done` pulse.
